// File: rtl/fir_tdm_scheduler.sv
// Sequencer for a time-multiplexed FIR: one shared MAC walks every tap per input sample.
// Owns the circular delay-line write pointer and zeroes the delay line after reset.
module fir_tdm_scheduler #(
    parameter int n_taps      = 8,
    parameter int mac_latency = 2,
    parameter int w_idx       = $clog2(n_taps)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             buf_we,
    output logic             buf_clr,
    output logic [w_idx-1:0] buf_waddr,
    output logic [w_idx-1:0] buf_raddr,
    output logic [w_idx-1:0] coef_idx,
    output logic             mac_en,
    output logic             mac_first,
    output logic             mac_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [15:0]      sample_count
);

    localparam int w_drain = (mac_latency > 1) ? $clog2(mac_latency) : 1;
    localparam logic [w_idx-1:0]   last_idx   = w_idx'(n_taps - 1);
    localparam logic [w_idx:0]     n_taps_w   = (w_idx + 1)'(n_taps);
    localparam logic [w_drain-1:0] drain_init = w_drain'((mac_latency > 0) ? mac_latency - 1 : 0);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [w_idx-1:0]   init_cnt_q, init_cnt_d;
    logic [w_idx-1:0]   wr_ptr_q, wr_ptr_d;
    logic [w_idx-1:0]   base_q, base_d;
    logic [w_idx-1:0]   tap_q, tap_d;
    logic [w_drain-1:0] drain_cnt_q, drain_cnt_d;
    logic [15:0]        sample_count_q, sample_count_d;

    // Tap k reads the sample k inputs older than the newest one, wrapping modulo n_taps.
    logic [w_idx:0]   wrap_sum;
    logic [w_idx-1:0] rd_addr;

    always_comb begin
        wrap_sum = {1'b0, base_q} + n_taps_w - {1'b0, tap_q};
        rd_addr  = (base_q >= tap_q) ? (base_q - tap_q) : wrap_sum[w_idx-1:0];
    end

    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        base_d         = base_q;
        tap_d          = tap_q;
        drain_cnt_d    = drain_cnt_q;
        sample_count_d = sample_count_q;

        in_ready  = 1'b0;
        buf_we    = 1'b0;
        buf_clr   = 1'b0;
        buf_waddr = '0;
        buf_raddr = '0;
        coef_idx  = '0;
        mac_en    = 1'b0;
        mac_first = 1'b0;
        mac_last  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_INIT: begin
                buf_we    = 1'b1;
                buf_clr   = 1'b1;
                buf_waddr = init_cnt_q;
                if (init_cnt_q == last_idx) begin
                    init_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                in_ready  = 1'b1;
                buf_we    = in_valid;
                buf_waddr = wr_ptr_q;
                if (in_valid) begin
                    base_d   = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == last_idx) ? '0 : wr_ptr_q + 1'b1;
                    tap_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                mac_en    = 1'b1;
                coef_idx  = tap_q;
                buf_raddr = rd_addr;
                mac_first = (tap_q == '0);
                mac_last  = (tap_q == last_idx);
                if (tap_q == last_idx) begin
                    tap_d = '0;
                    if (mac_latency == 0) begin
                        state_d = S_HOLD;
                    end else begin
                        drain_cnt_d = drain_init;
                        state_d     = S_DRAIN;
                    end
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sample_count_d = sample_count_q + 16'd1;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign sample_count = sample_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_INIT;
            init_cnt_q     <= '0;
            wr_ptr_q       <= '0;
            base_q         <= '0;
            tap_q          <= '0;
            drain_cnt_q    <= '0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            base_q         <= base_d;
            tap_q          <= tap_d;
            drain_cnt_q    <= drain_cnt_d;
            sample_count_q <= sample_count_d;
        end
    end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Bench for fir_tdm_scheduler: two configurations (8 taps/latency 2, 5 taps/latency 0) run side by side.
// Each lane has a driver that predicts the schedule into queues and a monitor that pops and compares.
module tb_fir_tdm_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input int ln, input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", ln, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int nt = (g == 0) ? 8 : 5;
        localparam int ml = (g == 0) ? 2 : 0;
        localparam int w  = $clog2(nt);
        localparam int ew = 32 + 2 * w + 2;

        logic rst, in_valid, in_ready, buf_we, buf_clr, mac_en, mac_first, mac_last;
        logic out_valid, out_ready, busy;
        logic [w-1:0] buf_waddr, buf_raddr, coef_idx;
        logic [15:0] sample_count;
        logic done_flag = 1'b0;

        // Expected MAC issues {cycle, raddr, coef, first, last}, writes {cycle, waddr}, results {cycle, count}.
        logic [ew-1:0]   exp_q[$];
        logic [32+w-1:0] waddr_q[$];
        logic [47:0]     out_q[$];

        int wr_ptr_m = 0;
        int acc_cnt  = 0;
        bit pending  = 1'b0;

        fir_tdm_scheduler #(.n_taps(nt), .mac_latency(ml)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid), .in_ready(in_ready),
            .buf_we(buf_we), .buf_clr(buf_clr), .buf_waddr(buf_waddr),
            .buf_raddr(buf_raddr), .coef_idx(coef_idx),
            .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
            .out_valid(out_valid), .out_ready(out_ready),
            .busy(busy), .sample_count(sample_count)
        );

        task automatic accept_sample();
            int base;
            base = wr_ptr_m;
            waddr_q.push_back({32'(cyc), w'(base)});
            for (int k = 0; k < nt; k++) begin
                exp_q.push_back({32'(cyc + 1 + k), w'((base - k + nt) % nt), w'(k), (k == 0), (k == nt - 1)});
            end
            out_q.push_back({32'(cyc + nt + ml + 1), 16'(acc_cnt)});
            wr_ptr_m = (wr_ptr_m + 1) % nt;
            acc_cnt++;
        endtask

        task automatic cycle_step(input int pv, input int pr);
            @(posedge clk);
            #1;
            if (!pending) begin
                in_valid = ($urandom_range(1, 100) <= pv);
                pending  = in_valid;
            end
            out_ready = ($urandom_range(1, 100) <= pr);
            @(negedge clk);
            if (in_valid && in_ready) begin
                accept_sample();
                pending = 1'b0;
            end
        endtask

        task automatic reset_and_check(input int ncyc);
            rst      = 1'b1;
            in_valid = 1'b0;
            pending  = 1'b0;
            exp_q.delete();
            waddr_q.delete();
            out_q.delete();
            wr_ptr_m = 0;
            acc_cnt  = 0;
            #1;
            chk(g, "reset_flags", {in_ready, out_valid, mac_en, mac_first, mac_last, buf_we, buf_clr, busy},
                8'b0000_0111);
            chk(g, "reset_addrs", {buf_waddr, buf_raddr, coef_idx}, '0);
            chk(g, "reset_count", sample_count, 16'd0);
            repeat (ncyc) @(posedge clk);
            #2 rst = 1'b0;
            for (int k = 0; k < nt; k++) begin
                @(negedge clk);
                #1;
                chk(g, "init_clear", {in_ready, buf_we, buf_clr, buf_waddr}, {1'b0, 1'b1, 1'b1, w'(k)});
            end
            @(negedge clk);
            #1;
            chk(g, "ready_after_init", {in_ready, busy}, 2'b10);
        endtask

        task automatic run_samples(input int n, input int pv, input int pr);
            int target;
            int budget;
            target = acc_cnt + n;
            budget = n * 60 + 50;
            while (acc_cnt < target && budget > 0) begin
                cycle_step(pv, pr);
                budget--;
            end
            chk(g, "samples_accepted", (acc_cnt >= target), 1'b1);
        endtask

        task automatic drain();
            int budget;
            budget = 200;
            while ((pending || exp_q.size() != 0 || out_q.size() != 0) && budget > 0) begin
                cycle_step(0, 100);
                budget--;
            end
            repeat (2) cycle_step(0, 100);
            chk(g, "drain_in_time", (budget > 0), 1'b1);
        endtask

        initial begin : driver
            int budget;
            rst       = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            #1;
            reset_and_check(2);

            run_samples(1, 100, 100);
            drain();
            run_samples(10, 100, 100);
            drain();

            // Result held back for five extra cycles while a new sample waits.
            run_samples(1, 100, 0);
            budget = 60;
            while (!out_valid && budget > 0) begin
                cycle_step(0, 0);
                budget--;
            end
            chk(g, "bp_out_valid", out_valid, 1'b1);
            repeat (5) cycle_step(100, 0);
            drain();

            run_samples(40, 60, 60);
            drain();

            // Abort a sample in the middle of its tap sweep.
            run_samples(1, 100, 100);
            budget = 40;
            while (budget > 0) begin
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                #2;
                if (mac_en && coef_idx == w'(nt / 2)) break;
                budget--;
            end
            chk(g, "abort_point_reached", {mac_en, coef_idx}, {1'b1, w'(nt / 2)});
            reset_and_check(2);

            run_samples(5, 80, 70);
            drain();
            chk(g, "queues_empty", exp_q.size() + out_q.size() + waddr_q.size(), 0);
            done_flag = 1'b1;
        end

        initial begin : monitor
            logic prev_ov, prev_wait, hs_pending;
            logic [15:0] hs_exp, cur_cnt;
            logic [47:0] res;
            prev_ov    = 1'b0;
            prev_wait  = 1'b0;
            hs_pending = 1'b0;
            hs_exp     = '0;
            cur_cnt    = '0;
            forever begin
                @(negedge clk);
                #1;
                if (rst) begin
                    prev_ov    = 1'b0;
                    prev_wait  = 1'b0;
                    hs_pending = 1'b0;
                end else begin
                    if (hs_pending) chk(g, "count_after_handshake", sample_count, hs_exp);
                    if (prev_wait) begin
                        chk(g, "hold_out_valid", out_valid, 1'b1);
                        chk(g, "hold_in_ready", in_ready, 1'b0);
                        chk(g, "hold_count", sample_count, cur_cnt);
                    end
                    if (buf_we && !buf_clr) begin
                        if (waddr_q.size() == 0) chk(g, "write_expected", waddr_q.size(), 1);
                        else chk(g, "write_addr", {32'(cyc), buf_waddr}, waddr_q.pop_front());
                    end
                    if (mac_en) begin
                        if (exp_q.size() == 0) chk(g, "mac_expected", exp_q.size(), 1);
                        else chk(g, "mac_op", {32'(cyc), buf_raddr, coef_idx, mac_first, mac_last},
                                 exp_q.pop_front());
                    end else begin
                        chk(g, "idle_tap_outputs", {buf_raddr, coef_idx, mac_first, mac_last}, '0);
                    end
                    if (out_valid && !prev_ov) begin
                        if (out_q.size() == 0) begin
                            chk(g, "result_expected", out_q.size(), 1);
                        end else begin
                            res     = out_q.pop_front();
                            cur_cnt = res[15:0];
                            chk(g, "result_timing_count", {32'(cyc), sample_count}, res);
                        end
                    end
                    chk(g, "busy_vs_ready", busy, !in_ready);
                    hs_pending = out_valid && out_ready;
                    hs_exp     = cur_cnt + 16'd1;
                    prev_wait  = out_valid && !out_ready;
                    prev_ov    = out_valid;
                end
            end
        end
    end

    initial begin
        fork
            wait (lane[0].done_flag && lane[1].done_flag);
            begin
                #500000;
                miscompares++;
                $display("FAIL global_timeout: lanes not done, expected done by %0t", $time);
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_tdm_scheduler.md
Name: fir_tdm_scheduler

Overview:
- Sequences a time-multiplexed FIR filter that shares one multiply-accumulate unit across all taps.
- Owns the write pointer of the circular sample delay line.
- Clears the delay line after reset.
- For each accepted input sample, issues one MAC operation per tap: sample address, coefficient index and first/last flags.
- Raises out_valid when the accumulator result is stable, and holds it until the downstream consumer takes it.
- Sits between the switch/sample source and the display/sound sink in the filter lab datapath.

Parameters:
n_taps, 8, number of filter taps; integer >= 2; need not be a power of 2.
mac_latency, 2, cycles from the mac_last issue cycle until the accumulator output is final; integer >= 0.
w_idx, $clog2(n_taps), width of the address and index outputs.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  an input sample is presented to the delay line write port.
in_ready  output  1  scheduler can accept a sample this cycle.
buf_we  output  1  delay line write enable.
buf_clr  output  1  write zero instead of the input sample (INIT only).
buf_waddr  output  w_idx  delay line write address.
buf_raddr  output  w_idx  delay line read address for the current tap.
coef_idx  output  w_idx  coefficient ROM index for the current tap.
mac_en  output  1  MAC performs an operation this cycle.
mac_first  output  1  MAC loads the product instead of accumulating.
mac_last  output  1  final tap of the current sample.
out_valid  output  1  accumulator result is final and stable.
out_ready  input  1  consumer accepts the result.
busy  output  1  state is not IDLE.
sample_count  output  16  number of completed output handshakes; wraps modulo 2^16.

Behaviour:
- States: INIT, IDLE, RUN, DRAIN, HOLD. All state is held in flops cleared asynchronously by rst.
- Reset values: state=INIT, init_cnt=0, wr_ptr=0, base=0, tap=0, drain_cnt=0, sample_count=0.
  - in_ready=0, out_valid=0, mac_en=0, mac_first=0, mac_last=0.
  - buf_we=1, buf_clr=1, buf_waddr=0.
  - busy=1, buf_raddr=0, coef_idx=0.
- INIT:
  - Drives buf_we=1, buf_clr=1, buf_waddr=init_cnt.
  - init_cnt counts 0..n_taps-1, then state goes to IDLE. INIT lasts exactly n_taps cycles.
  - in_ready=0 throughout.
- IDLE:
  - in_ready=1 and busy=0.
  - buf_we = in_valid; buf_clr=0; buf_waddr=wr_ptr. These are combinational.
  - On in_valid: base<=wr_ptr; wr_ptr<=(wr_ptr==n_taps-1)?0:wr_ptr+1; tap<=0; state goes to RUN.
- RUN (exactly n_taps cycles):
  - mac_en=1; coef_idx=tap.
  - buf_raddr = (base - tap) modulo n_taps, so tap k reads the sample k inputs older than the newest.
  - mac_first = (tap==0); mac_last = (tap==n_taps-1).
  - in_ready=0 and buf_we=0.
  - When tap==n_taps-1: if mac_latency==0, go to HOLD; otherwise drain_cnt<=mac_latency-1 and go to DRAIN.
- DRAIN:
  - mac_en=0.
  - Decrements drain_cnt; when drain_cnt==0, go to HOLD. DRAIN lasts exactly mac_latency cycles.
- HOLD:
  - out_valid=1 (state decode).
  - On out_ready: sample_count increments and state goes to IDLE. If out_ready is already high, HOLD lasts one cycle.
- Timing for a sample accepted in cycle T0:
  - Taps are issued in T1..Tn (n = n_taps).
  - out_valid first rises in cycle Tn+mac_latency+1.
  - Minimum spacing between accepted samples is n_taps+mac_latency+2 cycles.
- in_valid while in_ready=0 is ignored. The source must hold its sample until accepted.
- Asserting rst in any state (including mid-RUN or in HOLD) aborts the operation:
  - Any pending result is lost and out_valid falls immediately.
  - After release, INIT is rerun and the delay line is zeroed again.
- Outputs not listed for a state are 0. buf_raddr and coef_idx are 0 outside RUN.

Test Plan:
- Reset release: hold rst for 2 cycles, then release -> buf_we=buf_clr=1 with buf_waddr 0..7 over 8 cycles; in_ready rises on cycle 9; sample_count=0.
- Single sample, n_taps=8, mac_latency=2, out_ready=1: accept at T0 with wr_ptr=0 -> buf_raddr sequence 0,7,6,5,4,3,2,1; coef_idx 0..7; mac_first only at T1, mac_last only at T8; out_valid for one cycle at T11; sample_count=1.
- Pointer wrap: 10 back-to-back samples -> write addresses 0..7,0,1; the tenth sample has base=1 and read sequence 1,0,7,6,5,4,3,2.
- Back-pressure: out_ready=0 for 5 cycles in HOLD -> out_valid stays high, in_ready stays 0, and in_valid is ignored; out_ready=1 -> IDLE next cycle, and sample_count increments exactly once.
- Reset mid-RUN at tap 4 -> mac_en falls asynchronously; INIT reruns; wr_ptr=0; no out_valid is produced for the aborted sample.
- mac_latency=0 and n_taps=5 (non-power-of-2): with base=0 the read sequence is 0,4,3,2,1; out_valid is high in the cycle right after mac_last; wr_ptr wraps from 4 to 0.
